mem_port_arbiter: RTL and testbench

Shares one unified memory port between the instruction-fetch requester (imem) and the memory-stage requester (dmem) of the pipelined core. A three-state FSM grants one requester at a time and latches its request. It holds that request stable on the memory port until `mem_resp`, then routes the one-cycle response back to the granted requester. The non-granted requester sees no response and stays stalled, which drives the pipeline's existing freeze logic.

---
 rtl/mem_port_arbiter_pkg.sv | 11 +
 rtl/mem_port_arbiter_arb_pick.sv | 18 +
 rtl/mem_port_arbiter.sv | 76 +++++++
 tb/tb_mem_port_arbiter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rv32i_types: shared RV32I types, including the unified memory-port arbiter state and request.
// The arbiter's round-robin option is controlled by the ARB_FAIR_EN macro.
package rv32i_types;
  typedef enum logic [1:0] {ARB_IDLE, ARB_IMEM, ARB_DMEM} arb_state_t;
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } mem_req_t;
endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// arb_pick: combinational winner selection between fetch and data requesters.
// ARB_FAIR_EN selects round-robin; otherwise dmem has fixed priority.
module arb_pick (
  input  logic i_pend,
  input  logic d_pend,
  input  logic last_grant,
  output logic grant_i,
  output logic grant_d
);
`ifdef ARB_FAIR_EN
  assign grant_d = d_pend & (~i_pend | ~last_grant);
`else
  logic unused;
  assign unused = last_grant;
  assign grant_d = d_pend;
`endif
  assign grant_i = i_pend & ~grant_d;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between imem and dmem, one request at a time.
// Define ARB_FAIR_EN for round-robin priority instead of fixed dmem priority.
module mem_port_arbiter
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp,
  output logic [31:0] perf_conflicts
);
  arb_state_t state;
  mem_req_t   req, i_req, d_req;
  logic       i_pend, d_pend, pick_i, pick_d, grant_i, grant_d, conflict, last_grant;
  assign i_pend     = |imem_rmask;
  assign d_pend     = |(dmem_rmask | dmem_wmask);
  assign imem_resp  = state == ARB_IMEM && mem_resp;
  assign dmem_resp  = state == ARB_DMEM && mem_resp;
  assign imem_rdata = mem_rdata;
  assign dmem_rdata = mem_rdata;
  // In a resp cycle only the other requester may be picked; the served one's request is stale.
  assign pick_i = i_pend && (state == ARB_IDLE || dmem_resp);
  assign pick_d = d_pend && (state == ARB_IDLE || imem_resp);
  arb_pick u_pick (
    .i_pend(pick_i),
    .d_pend(pick_d),
    .last_grant(last_grant),
    .grant_i(grant_i),
    .grant_d(grant_d)
  );
  assign i_req = '{addr: imem_addr, rmask: imem_rmask, wmask: 4'h0, wdata: 32'h0};
  assign d_req = '{addr: dmem_addr, rmask: dmem_rmask, wmask: dmem_wmask, wdata: dmem_wdata};
  assign {mem_addr, mem_rmask, mem_wmask, mem_wdata} = state == ARB_IDLE ? '0 : req;
  assign conflict = (i_pend && !grant_i && state != ARB_IMEM) ||
                    (d_pend && !grant_d && state != ARB_DMEM);
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ARB_IDLE;
      req            <= '0;
      perf_conflicts <= '0;
    end else begin
      if (grant_d) begin
        state <= ARB_DMEM;
        req   <= d_req;
      end else if (grant_i) begin
        state <= ARB_IMEM;
        req   <= i_req;
      end else if (mem_resp && state != ARB_IDLE) begin
        state <= ARB_IDLE;
      end
      if (conflict && perf_conflicts != '1) perf_conflicts <= perf_conflicts + 32'd1;
    end
  end
`ifdef ARB_FAIR_EN
  always_ff @(posedge clk) begin
    if (rst) last_grant <= 1'b0;
    else if (grant_i || grant_d) last_grant <= grant_d;
  end
`else
  assign last_grant = 1'b0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter with a wait-state memory model.
module tb_mem_port_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] imem_addr, dmem_addr, dmem_wdata, imem_rdata, dmem_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, perf_conflicts;
  logic [3:0]  imem_rmask, dmem_rmask, dmem_wmask, mem_rmask, mem_wmask;
  logic        imem_resp, dmem_resp, mem_resp, mresp, spur;
  int          cnt, wait_cyc, errors, checks;
  typedef struct {logic d; logic [31:0] addr;} exp_t;
  exp_t sb[$];

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .perf_conflicts(perf_conflicts)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] f(logic [31:0] a);
    return (a ^ 32'h6000_0000) + 32'h13;
  endfunction

  // Memory answers wait_cyc+1 cycles after a request first appears on the port.
  always @(posedge clk) begin
    if (rst) begin
      mresp <= 1'b0;
      cnt   <= 0;
    end else if (mresp) begin
      mresp <= 1'b0;
      cnt   <= 0;
    end else if (|mem_rmask || |mem_wmask) begin
      if (cnt == wait_cyc) mresp <= 1'b1;
      else cnt <= cnt + 1;
    end
  end
  assign mem_resp  = mresp | spur;
  assign mem_rdata = mem_resp ? f(mem_addr) : 32'h0;

  always @(negedge clk)
    assert (!(|dmem_rmask && |dmem_wmask))
      else $error("FAIL illegal_dmem_mask rmask=%h wmask=%h", dmem_rmask, dmem_wmask);

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic req_i(logic [31:0] a);
    imem_addr  = a;
    imem_rmask = 4'hF;
    sb.push_back('{1'b0, a});
  endtask

  task automatic req_d(logic [31:0] a, logic [3:0] rm, logic [3:0] wm, logic [31:0] wd);
    dmem_addr  = a;
    dmem_rmask = rm;
    dmem_wmask = wm;
    dmem_wdata = wd;
    sb.push_back('{1'b1, a});
  endtask

  task automatic wait_resp(string tag);
    exp_t e;
    logic got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = imem_resp | dmem_resp;
    end
    chk({tag, "_resp_seen"}, {31'h0, got}, 32'h1);
    if (!got || sb.size() == 0) return;
    e = sb.pop_front();
    chk({tag, "_who"}, {30'h0, dmem_resp, imem_resp}, e.d ? 32'h2 : 32'h1);
    chk({tag, "_addr"}, mem_addr, e.addr);
    chk({tag, "_rdata"}, e.d ? dmem_rdata : imem_rdata, f(e.addr));
    if (e.d) begin
      dmem_rmask = 4'h0;
      dmem_wmask = 4'h0;
    end else imem_rmask = 4'h0;
  endtask

  initial begin
    imem_addr = 0; imem_rmask = 0; dmem_addr = 0; dmem_rmask = 0; dmem_wmask = 0; dmem_wdata = 0;
    spur = 1'b0; wait_cyc = 1; errors = 0; checks = 0;
    repeat (2) @(negedge clk);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_masks", {24'h0, mem_rmask, mem_wmask}, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_resp", {30'h0, imem_resp, dmem_resp}, 32'h0);
    chk("rst_perf", perf_conflicts, 32'h0);
    rst = 1'b0;
    // single fetch
    @(negedge clk); req_i(32'h6000_0000);
    @(negedge clk);
    chk("fetch_rmask_n1", {28'h0, mem_rmask}, 32'hF);
    chk("fetch_addr_n1", mem_addr, 32'h6000_0000);
    wait_resp("fetch");
    @(negedge clk);
    chk("fetch_then_idle", {24'h0, mem_rmask, mem_wmask}, 32'h0);
    // simultaneous store + fetch, dmem first, fetch follows without a bubble
    req_d(32'h7000_0010, 4'h0, 4'b0100, 32'h00AB_0000);
    req_i(32'h6000_0004);
    @(negedge clk);
    chk("store_addr", mem_addr, 32'h7000_0010);
    chk("store_wmask", {28'h0, mem_wmask}, 32'h4);
    chk("store_rmask", {28'h0, mem_rmask}, 32'h0);
    chk("store_wdata", mem_wdata, 32'h00AB_0000);
    wait_resp("store");
    chk("conflicts_store", perf_conflicts, 32'd3);
    @(negedge clk);
    chk("b2b_fetch_addr", mem_addr, 32'h6000_0004);
    chk("b2b_fetch_rmask", {28'h0, mem_rmask}, 32'hF);
    wait_resp("fetch2");
    chk("conflicts_after", perf_conflicts, 32'd3);
    // same requester twice pays one idle cycle
    @(negedge clk); req_i(32'h6000_0008);
    wait_resp("fetch3");
    req_i(32'h6000_000C);
    @(negedge clk);
    chk("same_req_bubble", {28'h0, mem_rmask}, 32'h0);
    @(negedge clk);
    chk("same_req_addr", mem_addr, 32'h6000_000C);
    wait_resp("fetch4");
    // spurious mem_resp while idle
    @(negedge clk); spur = 1'b1; #1;
    chk("spur_no_resp", {30'h0, imem_resp, dmem_resp}, 32'h0);
    @(negedge clk); spur = 1'b0;
    chk("spur_state_idle", {24'h0, mem_rmask, mem_wmask}, 32'h0);
    chk("spur_addr_idle", mem_addr, 32'h0);
    // reset in the middle of a dmem access
    @(negedge clk); req_d(32'h7000_0020, 4'hF, 4'h0, 32'h0);
    @(negedge clk);
    chk("pre_rst_dmem", {28'h0, mem_rmask}, 32'hF);
    rst = 1'b1; dmem_rmask = 4'h0; sb.delete();
    @(negedge clk);
    chk("midrst_addr", mem_addr, 32'h0);
    chk("midrst_masks", {24'h0, mem_rmask, mem_wmask}, 32'h0);
    chk("midrst_dresp", {31'h0, dmem_resp}, 32'h0);
    chk("midrst_perf", perf_conflicts, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_no_resp", {30'h0, imem_resp, dmem_resp}, 32'h0);
`ifdef ARB_FAIR_EN
    req_d(32'h7000_0100, 4'hF, 4'h0, 32'h0);
    req_i(32'h6000_0100);
    for (int k = 0; k < 6; k++) begin
      wait_resp("fair");
      if (k < 4) begin
        if (k % 2 == 0) req_d(32'h7000_0104 + 32'(k * 4), 4'hF, 4'h0, 32'h0);
        else req_i(32'h6000_0104 + 32'(k * 4));
      end
    end
    @(negedge clk);
`endif
    // counter saturation
    force dut.perf_conflicts = 32'hFFFF_FFFE;
    req_d(32'h7000_0030, 4'h0, 4'h3, 32'h0000_1234);
    req_i(32'h6000_0030);
    #1 release dut.perf_conflicts;
    chk("sat_preload", perf_conflicts, 32'hFFFF_FFFE);
    wait_resp("sat_store");
    chk("sat_hold", perf_conflicts, 32'hFFFF_FFFF);
    wait_resp("sat_fetch");
    chk("sat_hold2", perf_conflicts, 32'hFFFF_FFFF);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
